// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter: state encoding,
// ALU op codes, default widths and the captured response flag bundle.
package alu_arb_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 3;

  // FSM encoding kept as plain constants so legacy decoders can match it
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_AND     = 3'd2,
    OP_OR      = 3'd3,
    OP_XOR     = 3'd4,
    OP_SLL     = 3'd5,
    OP_SRL     = 3'd6,
    OP_INVALID = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic err;
  } rsp_flags_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant: a lone requester always wins, a tie goes to prio.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  // one-hot grant; prio only matters when both requesters are valid
  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// One operation at a time: IDLE (accept) -> EXEC (ALU sees latched
// operands, result captured) -> RESP (hold until owner takes it).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zf,
  input  logic             alu_sf,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zf,
  output logic             rsp_sf,
  output logic             rsp_err,
  output logic             busy
);

  logic [1:0]       state;
  logic             prio;
  logic             owner;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic [OPW-1:0]   lat_op;
  logic [WIDTH-1:0] res_q;
  rsp_flags_t       flg_q;
  logic [1:0]       grant;
  logic             idle;
  logic             accept;

  rr_arb2 u_arb (
    .valid (req_valid),
    .prio  (prio),
    .grant (grant)
  );

  assign idle      = (state == ST_IDLE);
  assign busy      = !idle;
  assign req_ready = idle ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  // ALU inputs come straight from the latches so they hold outside EXEC
  assign alu_src_a   = lat_a;
  assign alu_src_b   = lat_b;
  assign alu_control = lat_op;

  assign rsp_valid  = (state == ST_RESP) ? {owner, ~owner} : 2'b00;
  assign rsp_result = res_q;
  assign rsp_zf     = flg_q.zf;
  assign rsp_sf     = flg_q.sf;
  assign rsp_err    = flg_q.err;

  // FSM, request latching and response capture; reset beats any handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      prio   <= 1'b0;
      owner  <= 1'b0;
      lat_a  <= '0;
      lat_b  <= '0;
      lat_op <= '0;
      res_q  <= '0;
      flg_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          owner  <= grant[1];
          prio   <= ~grant[1];
          lat_a  <= grant[1] ? req1_a  : req0_a;
          lat_b  <= grant[1] ? req1_b  : req0_b;
          lat_op <= grant[1] ? req1_op : req0_op;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          // undefined op still burns the EXEC cycle but reports a fixed error
          if (lat_op == OPW'(OP_INVALID)) begin
            res_q <= '0;
            flg_q <= '{zf: 1'b1, sf: 1'b0, err: 1'b1};
          end else begin
            res_q <= alu_result;
            flg_q <= '{zf: alu_zf, sf: alu_sf, err: 1'b0};
          end
          state <= ST_RESP;
        end
        ST_RESP: if (rsp_ready[owner]) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter with an external ALU model,
// a transaction-level reference model and a response scoreboard.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic [2:0]  alu_control;
  logic        alu_zf, alu_sf;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] rsp_result;
  logic        rsp_zf, rsp_sf, rsp_err, busy;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zf(alu_zf), .alu_sf(alu_sf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return 32'hDEAD_BEEF;  // garbage the arbiter must not forward
    endcase
  endfunction

  // external shared ALU
  always_comb begin
    alu_result = alu_fn(alu_src_a, alu_src_b, alu_control);
    alu_zf     = (alu_result == 32'd0);
    alu_sf     = alu_result[31];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic        zf, sf, err;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  int          cyc = 0;
  int          acc_cyc = 0;
  bit          started = 0, was_rst = 0, outst = 0;
  logic        m_owner = 0, m_prio = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [2:0]  m_op = '0;
  logic [1:0]  erv, erdy, g;

  function automatic logic [1:0] pick(logic [1:0] v, logic p);
    if (v[0] && v[1]) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  initial forever begin
    @(negedge clk);
    cyc++;
    if (started) begin
      erv  = (outst && cyc >= acc_cyc + 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      erdy = outst ? 2'b00 : pick(req_valid, m_prio);
      chk("busy", 32'(busy), 32'(outst));
      chk("req_ready", 32'(req_ready), 32'(erdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(erv));
      chk("alu_src_a", alu_src_a, m_a);
      chk("alu_src_b", alu_src_b, m_b);
      chk("alu_control", 32'(alu_control), 32'(m_op));
      if (rsp_valid != 2'b00 && sbq.size() > 0) begin
        chk("rsp_result", rsp_result, sbq[0].res);
        chk("rsp_flags", 32'({rsp_zf, rsp_sf, rsp_err}), 32'({sbq[0].zf, sbq[0].sf, sbq[0].err}));
      end
      if (was_rst) chk("rsp_after_reset", 32'({rsp_zf, rsp_sf, rsp_err}) | rsp_result, 32'd0);
    end
    if (reset) begin
      started = 1; was_rst = 1; outst = 0; m_prio = 0; m_owner = 0;
      m_a = '0; m_b = '0; m_op = '0;
      sbq.delete();
    end else begin
      was_rst = 0;
      if (!outst) begin
        g = pick(req_valid, m_prio);
        if (g != 2'b00) begin
          m_owner = g[1];
          m_prio  = !g[1];
          m_a  = g[1] ? req1_a  : req0_a;
          m_b  = g[1] ? req1_b  : req0_b;
          m_op = g[1] ? req1_op : req0_op;
          e.owner = m_owner;
          if (m_op == 3'd7) begin
            e.res = '0; e.zf = 1; e.sf = 0; e.err = 1;
          end else begin
            e.res = alu_fn(m_a, m_b, m_op);
            e.zf = (e.res == 0); e.sf = e.res[31]; e.err = 0;
          end
          sbq.push_back(e);
          outst = 1; acc_cyc = cyc;
        end
      end else if (cyc >= acc_cyc + 2 && rsp_ready[m_owner]) begin
        void'(sbq.pop_front());
        outst = 0;
      end
    end
  end

  // ---------------- driver ----------------
  logic [1:0] hs;
  logic       bsy;

  task automatic step();
    @(negedge clk);
    hs  = req_valid & req_ready;
    bsy = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (i == 0) begin req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_a = a; req1_b = b; req1_op = op; end
    req_valid[i] = 1'b1;
  endtask

  task automatic timeout(input string nm);
    total++; bad++;
    $display("FAIL %s act=no_event exp=event t=%0t", nm, $time);
  endtask

  task automatic send1(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit done = 0;
    set_req(i, a, b, op);
    for (int n = 0; n < 60 && !done; n++) begin
      step();
      if (hs[i]) done = 1;
    end
    if (!done) timeout("accept_timeout");
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      step();
      if (!bsy) done = 1;
    end
    if (!done) timeout("idle_timeout");
  endtask

  initial begin
    bit done;
    step(); step();
    reset = 0;

    // lone req0: 5+3
    send1(0, 32'd5, 32'd3, 3'd0);
    wait_idle();

    // both valid right after reset: req0 first, then req1 3-5
    reset = 1; step(); reset = 0;
    set_req(0, 32'd10, 32'd20, 3'd0);
    set_req(1, 32'd3, 32'd5, 3'd1);
    done = 0;
    for (int n = 0; n < 80 && !done; n++) begin
      step();
      if (hs[0]) req_valid[0] = 1'b0;
      if (hs[1]) req_valid[1] = 1'b0;
      if (req_valid == 2'b00) done = 1;
    end
    if (!done) timeout("dual_timeout");
    wait_idle();

    // response back-pressure with req1 waiting
    rsp_ready = 2'b00;
    send1(0, 32'd100, 32'd1, 3'd4);
    set_req(1, 32'd9, 32'd2, 3'd6);
    repeat (5) step();
    rsp_ready = 2'b10;  // non-owner ready must be ignored
    repeat (2) step();
    rsp_ready = 2'b11;
    done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      step();
      if (hs[1]) done = 1;
    end
    if (!done) timeout("req1_timeout");
    req_valid[1] = 1'b0;
    wait_idle();

    // zero flag, then undefined op
    send1(1, 32'd7, 32'd7, 3'd1);
    wait_idle();
    send1(1, 32'd1234, 32'd5, 3'd7);
    wait_idle();

    // reset during EXEC discards the op
    send1(0, 32'd2, 32'd2, 3'd0);
    reset = 1; step(); reset = 0;
    step();
    send1(0, 32'd1, 32'd4, 3'd5);
    wait_idle();

    // request withdrawn while busy leaves no trace
    send1(0, 32'hFFFF_FFFF, 32'd1, 3'd0);
    set_req(1, 32'd8, 32'd8, 3'd2);
    step();
    req_valid[1] = 1'b0;
    wait_idle();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          logic [31:0] ra, rb;
          ra = $urandom;
          rb = ($urandom_range(3) == 0) ? ra : (($urandom_range(1) == 0) ? 32'($urandom_range(40)) : $urandom);
          set_req(i, ra, rb, 3'($urandom_range(7)));
        end else if (req_valid[i] && !hs[i] && $urandom_range(19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
      reset = ($urandom_range(199) == 0);
    end
    reset = 0; rsp_ready = 2'b11; req_valid = 2'b00;
    wait_idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have parameter: OPW, 3, ALU control width.
REQ-003 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: req_valid  in  2  per-requester request strobe, bit i = requester i.
REQ-006 SHALL have ports: req_ready  out  2  per-requester accept.
REQ-007 SHALL have ports: req0_a / req0_b  in  WIDTH  requester 0 operands; req0_op  in  OPW  requester 0 operation.
REQ-008 SHALL have ports: req1_a / req1_b  in  WIDTH  requester 1 operands; req1_op  in  OPW  requester 1 operation.
REQ-009 SHALL have ports: alu_src_a / alu_src_b  out  WIDTH, and alu_control  out  OPW, all driving the shared combinational ALU.
REQ-010 SHALL have ports: alu_result  in  WIDTH, alu_zf  in  1, and alu_sf  in  1, all returned from the shared ALU.
REQ-011 SHALL have ports: rsp_valid  out  2  one-hot response strobe to the owning requester.
REQ-012 SHALL have ports: rsp_ready  in  2  per-requester response accept.
REQ-013 SHALL have ports: rsp_result  out  WIDTH; rsp_zf, rsp_sf, rsp_err  out  1 each; busy  out  1.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; busy = (state != IDLE).
REQ-015 SHALL assert req_ready only in IDLE, at most one bit, to the granted requester.
REQ-016 Grant SHALL go to the sole valid requester; when both are valid, to the requester selected by the priority pointer prio (0 selects requester 0).
REQ-017 Handshake SHALL complete when req_valid[i] && req_ready[i]; in that cycle the block SHALL latch operands, op and owner id, set prio to the other requester, and enter EXEC.
REQ-018 In EXEC, alu_src_a/alu_src_b/alu_control SHALL present the latched values; at cycle end, alu_result/zf/sf SHALL be captured into rsp registers, and the FSM SHALL enter RESP.
REQ-019 Latency: an accept at edge N SHALL yield rsp_valid[owner]=1 from edge N+2.
REQ-020 In RESP, rsp_valid[owner] SHALL remain 1 with rsp_result/zf/sf/err stable until rsp_ready[owner]=1, then the FSM SHALL return to IDLE; rsp_ready of the non-owner SHALL be ignored.
REQ-021 No request SHALL be accepted in EXEC or RESP (minimum 3 cycles per operation); a pending request SHALL be held by its requester.
REQ-022 alu_* outputs SHALL hold the last latched values outside EXEC.
REQ-023 op 3'b111 (undefined) SHALL still pass through EXEC; the block SHALL capture rsp_result=0, rsp_zf=1, rsp_sf=0, rsp_err=1.
REQ-024 rsp_err SHALL be 0 for ops 0-6.
REQ-025 A requester dropping req_valid before the handshake SHALL cause no state change; prio SHALL change only on accept.

Reset
REQ-026 reset SHALL force state IDLE, prio=0, all latched operands/op/owner=0, and all response registers=0, taking effect at the next edge and overriding any handshake in that cycle.
REQ-027 After reset, outputs SHALL read req_ready derived from IDLE, rsp_valid=0, rsp_result=0, rsp_zf/sf/err=0, alu_*=0, busy=0.
REQ-028 Reset asserted in EXEC or RESP SHALL discard the operation; no response SHALL be issued for it.

Structure
REQ-029 Package alu_arb_pkg SHALL hold the state encoding, ALU op constants (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, INVALID=7), and default WIDTH/OPW.
REQ-030 The two-way round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: valid[1:0], prio; output: one-hot grant).
REQ-031 The ALU SHALL remain external to this block.

Verification
REQ-032 Scenario: req0 alone, a=5, b=3, op=0 -> rsp_valid=2'b01 two edges after accept; rsp_result=8, zf=0, sf=0.
REQ-033 Scenario: both valid in the first cycle after reset (req1 op=1, a=3, b=5) -> req0 served first; req1 accepted next, giving rsp_result=0xFFFFFFFE, sf=1.
REQ-034 Scenario: rsp_ready held 0 for 4 cycles while req1 is valid -> response data is stable, req_ready=0 throughout, and req1 is accepted only after rsp_ready[owner].
REQ-035 Scenario: req1 a=7, b=7, op=1 -> zf=1, result=0; then op=7 -> rsp_err=1, result=0.
REQ-036 Scenario: reset asserted during EXEC -> rsp_valid stays 0 and busy=0 next cycle; a following req0 (a=1, b=4, op=5) returns 16.
